// File: rtl/bnn_pkg.sv
// Shared types and constants for the BNN inference path.
// State encodings are fixed because seq_state is exported for debug.
package bnn_pkg;

    localparam int RESULT_W = 4;
    localparam int IMG_BITS = 904;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_FULL = 3'd1,
        LAUNCH    = 3'd2,
        RUN       = 3'd3,
        HOLD      = 3'd4,
        FLUSH     = 3'd5,
        FAULT     = 3'd6
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_TIMEOUT   = 2'd1,
        ERR_BAD_CLASS = 2'd2,
        ERR_ABORT     = 2'd3
    } seq_err_t;

endpackage

// File: rtl/watchdog_counter.sv
// Free-running cycle counter with synchronous clear; flags the cycle on which
// the count sits at LIMIT-1, i.e. the LIMIT-th enabled cycle after a load.
module watchdog_counter #(
    parameter int LIMIT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/inference_sequencer.sv
// Runs one BNN inference per host request: waits for a full frame, launches,
// supervises with watchdog/retries, holds the class until acked, then flushes.
module inference_sequencer
    import bnn_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRIES    = 2,
    parameter int NUM_CLASSES    = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_req,
    input  logic                abort,
    input  logic                buffer_full,
    input  logic                bnn_result_ready,
    input  logic [RESULT_W-1:0] bnn_result_in,
    output logic                bnn_start,
    output logic                clear_buffer,
    output logic [RESULT_W-1:0] result_out,
    output logic                result_valid,
    input  logic                result_ack,
    output logic                busy,
    output logic                err,
    output logic [1:0]          err_code,
    output logic [15:0]         infer_count,
    output logic [2:0]          seq_state
);

    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int CLS_W   = RESULT_W + 1;

    seq_state_t          state_reg, state_next;
    seq_err_t            err_code_reg, err_code_next;
    logic [RETRY_W-1:0]  retry_reg, retry_next;
    logic                err_reg, err_next;
    logic [RESULT_W-1:0] result_reg, result_next;
    logic [15:0]         infer_count_reg, infer_count_next;
    logic                bnn_start_reg, clear_buffer_reg, result_valid_reg, busy_reg;
    logic                wd_expired;
    logic                class_ok;

    watchdog_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (state_reg == LAUNCH),
        .en      (state_reg == RUN),
        .expired (wd_expired)
    );

    // Widen by one bit so NUM_CLASSES = 16 still compares correctly.
    assign class_ok = ({1'b0, bnn_result_in} < CLS_W'(NUM_CLASSES));

    always_comb begin
        state_next       = state_reg;
        err_code_next    = err_code_reg;
        retry_next       = retry_reg;
        err_next         = err_reg;
        result_next      = result_reg;
        infer_count_next = infer_count_reg;
        case (state_reg)
            IDLE: begin
                if (start_req) begin
                    state_next    = WAIT_FULL;
                    err_next      = 1'b0;
                    err_code_next = ERR_NONE;
                    retry_next    = '0;
                end
            end
            WAIT_FULL, LAUNCH: begin
                if (abort) begin
                    state_next    = FLUSH;
                    err_code_next = ERR_ABORT;
                end else if (state_reg == LAUNCH) begin
                    state_next = RUN;
                end else if (buffer_full) begin
                    state_next = LAUNCH;
                end
            end
            RUN: begin
                // abort beats ready, and ready beats a simultaneous expiry
                if (abort) begin
                    state_next    = FLUSH;
                    err_code_next = ERR_ABORT;
                end else if (bnn_result_ready) begin
                    if (class_ok) begin
                        result_next = bnn_result_in;
                        state_next  = HOLD;
                    end else begin
                        err_code_next = ERR_BAD_CLASS;
                        err_next      = 1'b1;
                        state_next    = FAULT;
                    end
                end else if (wd_expired) begin
                    if (retry_reg < RETRY_W'(MAX_RETRIES)) begin
                        retry_next = retry_reg + 1'b1;
                        state_next = LAUNCH;
                    end else begin
                        err_code_next = ERR_TIMEOUT;
                        err_next      = 1'b1;
                        state_next    = FAULT;
                    end
                end
            end
            HOLD: begin
                if (abort) begin
                    state_next    = FLUSH;
                    err_code_next = ERR_ABORT;
                end else if (result_ack) begin
                    state_next = FLUSH;
                    if (infer_count_reg != 16'hFFFF) begin
                        infer_count_next = infer_count_reg + 16'd1;
                    end
                end
            end
            FAULT:   state_next = FLUSH;
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pulse/level outputs are registered from the next state so they line up
    // exactly with the cycle spent in that state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            err_code_reg     <= ERR_NONE;
            retry_reg        <= '0;
            err_reg          <= 1'b0;
            result_reg       <= '0;
            infer_count_reg  <= '0;
            bnn_start_reg    <= 1'b0;
            clear_buffer_reg <= 1'b0;
            result_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            err_code_reg     <= err_code_next;
            retry_reg        <= retry_next;
            err_reg          <= err_next;
            result_reg       <= result_next;
            infer_count_reg  <= infer_count_next;
            bnn_start_reg    <= (state_next == LAUNCH);
            clear_buffer_reg <= (state_next == FLUSH);
            result_valid_reg <= (state_next == HOLD);
            busy_reg         <= (state_next != IDLE);
        end
    end

    assign bnn_start    = bnn_start_reg;
    assign clear_buffer = clear_buffer_reg;
    assign result_out   = result_reg;
    assign result_valid = result_valid_reg;
    assign busy         = busy_reg;
    assign err          = err_reg;
    assign err_code     = err_code_reg;
    assign infer_count  = infer_count_reg;
    assign seq_state    = state_reg;

endmodule
